// File: rtl/entropy_seq_pkg.sv
// Shared types and sizing for the entropy encoder front-end sequencer.
package entropy_seq_pkg;

    localparam int unsigned RANGE_WIDTH    = 16;
    localparam int unsigned SYMBOL_WIDTH   = 4;
    localparam int unsigned NSYMS_WIDTH    = SYMBOL_WIDTH + 1;
    localparam int unsigned LANES          = 3;
    localparam int unsigned LANE_CNT_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Staged group: shared bounds plus up to three lane symbols.
    typedef struct packed {
        logic [LANE_CNT_WIDTH-1:0]          count;
        logic                               closed;
        logic                               is_bool;
        logic                               last;
        logic [RANGE_WIDTH-1:0]             fl;
        logic [RANGE_WIDTH-1:0]             fh;
        logic [NSYMS_WIDTH-1:0]             nsyms;
        logic [LANES-1:0][SYMBOL_WIDTH-1:0] sym;
    } acc_t;

endpackage

// File: rtl/bool_lane_packer.sv
// Accumulates compatible bool symbols into three lanes and issues groups to the encoder.
module bool_lane_packer
    import entropy_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic [RANGE_WIDTH-1:0]  d_fl,
    input  logic [RANGE_WIDTH-1:0]  d_fh,
    input  logic [SYMBOL_WIDTH-1:0] d_symbol,
    input  logic [NSYMS_WIDTH-1:0]  d_nsyms,
    input  logic                    d_bool,
    input  logic                    d_last,
    output logic                    issue_c,
    output logic                    issue_last_c,
    output logic                    enc_valid,
    output logic [RANGE_WIDTH-1:0]  enc_fl,
    output logic [RANGE_WIDTH-1:0]  enc_fh,
    output logic [NSYMS_WIDTH-1:0]  enc_nsyms,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_3,
    output logic                    enc_bool_1,
    output logic                    enc_bool_2,
    output logic                    enc_bool_3
);

    localparam logic [LANE_CNT_WIDTH-1:0] CNT_ONE  = LANE_CNT_WIDTH'(1);
    localparam logic [LANE_CNT_WIDTH-1:0] CNT_LAST = LANE_CNT_WIDTH'(LANES - 1);
    localparam logic [LANE_CNT_WIDTH-1:0] CNT_FULL = LANE_CNT_WIDTH'(LANES);

    acc_t acc;
    acc_t acc_nxt;
    logic open_c;
    logic compat_c;

    // Compatibility, issue decision and next accumulator contents.
    always_comb begin
        open_c       = (acc.count != '0) && !acc.closed;
        compat_c     = d_bool && open_c && acc.is_bool && (d_fl == acc.fl) && (acc.count < CNT_FULL);
        issue_c      = ((acc.count != '0) && acc.closed) || (accept && open_c && !compat_c);
        issue_last_c = issue_c && acc.last;
        acc_nxt      = issue_c ? '0 : acc;
        if (accept) begin
            if (compat_c) begin
                acc_nxt.sym[acc.count] = d_symbol;
                acc_nxt.count          = acc.count + CNT_ONE;
                acc_nxt.last           = d_last;
                acc_nxt.closed         = d_last || (acc.count == CNT_LAST);
            end else begin
                acc_nxt         = '0;
                acc_nxt.count   = CNT_ONE;
                acc_nxt.is_bool = d_bool;
                acc_nxt.last    = d_last;
                acc_nxt.closed  = d_last || !d_bool;
                acc_nxt.fl      = d_fl;
                acc_nxt.fh      = d_fh;
                acc_nxt.nsyms   = d_nsyms;
                acc_nxt.sym[0]  = d_symbol;
            end
        end
    end

    // Accumulator state and registered encoder issue port (zero when idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            enc_valid    <= 1'b0;
            enc_fl       <= '0;
            enc_fh       <= '0;
            enc_nsyms    <= '0;
            enc_symbol_1 <= '0;
            enc_symbol_2 <= '0;
            enc_symbol_3 <= '0;
            enc_bool_1   <= 1'b0;
            enc_bool_2   <= 1'b0;
            enc_bool_3   <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            enc_valid <= issue_c;
            if (issue_c) begin
                enc_fl       <= acc.fl;
                enc_fh       <= acc.is_bool ? '0 : acc.fh;
                enc_nsyms    <= acc.is_bool ? NSYMS_WIDTH'(2) : acc.nsyms;
                enc_symbol_1 <= acc.sym[0];
                enc_symbol_2 <= acc.sym[1];
                enc_symbol_3 <= acc.sym[2];
                enc_bool_1   <= acc.is_bool && (acc.count > LANE_CNT_WIDTH'(0));
                enc_bool_2   <= acc.is_bool && (acc.count > LANE_CNT_WIDTH'(1));
                enc_bool_3   <= acc.is_bool && (acc.count > LANE_CNT_WIDTH'(2));
            end else begin
                enc_fl       <= '0;
                enc_fh       <= '0;
                enc_nsyms    <= '0;
                enc_symbol_1 <= '0;
                enc_symbol_2 <= '0;
                enc_symbol_3 <= '0;
                enc_bool_1   <= 1'b0;
                enc_bool_2   <= 1'b0;
                enc_bool_3   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/entropy_encoder_sequencer.sv
// Frame sequencer: packs descriptors for entropy_encoder and paces frames against its drain.
module entropy_encoder_sequencer
    import entropy_seq_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH     = 7
) (
    input  logic                    top_clk,
    input  logic                    top_reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [RANGE_WIDTH-1:0]  s_fl,
    input  logic [RANGE_WIDTH-1:0]  s_fh,
    input  logic [SYMBOL_WIDTH-1:0] s_symbol,
    input  logic [NSYMS_WIDTH-1:0]  s_nsyms,
    input  logic                    s_bool,
    input  logic                    s_last,
    output logic                    enc_valid,
    output logic [RANGE_WIDTH-1:0]  enc_fl,
    output logic [RANGE_WIDTH-1:0]  enc_fh,
    output logic [NSYMS_WIDTH-1:0]  enc_nsyms,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_3,
    output logic                    enc_bool_1,
    output logic                    enc_bool_2,
    output logic                    enc_bool_3,
    output logic                    enc_flag_first,
    output logic                    enc_final_flag,
    input  logic                    enc_last_in,
    output logic                    busy,
    output logic                    err_timeout
);

    seq_state_e           state;
    logic                 first_pending;
    logic [CNT_WIDTH-1:0] drain_cnt;
    logic                 accept;
    logic                 issue_c;
    logic                 issue_last_c;

    assign accept = s_valid && s_ready;

    bool_lane_packer u_packer (
        .clk          (top_clk),
        .rst          (top_reset),
        .accept       (accept),
        .d_fl         (s_fl),
        .d_fh         (s_fh),
        .d_symbol     (s_symbol),
        .d_nsyms      (s_nsyms),
        .d_bool       (s_bool),
        .d_last       (s_last),
        .issue_c      (issue_c),
        .issue_last_c (issue_last_c),
        .enc_valid    (enc_valid),
        .enc_fl       (enc_fl),
        .enc_fh       (enc_fh),
        .enc_nsyms    (enc_nsyms),
        .enc_symbol_1 (enc_symbol_1),
        .enc_symbol_2 (enc_symbol_2),
        .enc_symbol_3 (enc_symbol_3),
        .enc_bool_1   (enc_bool_1),
        .enc_bool_2   (enc_bool_2),
        .enc_bool_3   (enc_bool_3)
    );

    // Frame FSM with registered handshake, frame flags and drain watchdog.
    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            state          <= IDLE;
            s_ready        <= 1'b1;
            busy           <= 1'b0;
            enc_flag_first <= 1'b0;
            enc_final_flag <= 1'b0;
            err_timeout    <= 1'b0;
            first_pending  <= 1'b1;
            drain_cnt      <= '0;
        end else begin
            enc_flag_first <= issue_c && first_pending;
            enc_final_flag <= 1'b0;
            if (issue_c) begin
                first_pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        if (s_last) begin
                            s_ready <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept && s_last) begin
                        s_ready <= 1'b0;
                    end
                    if (issue_last_c) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    state          <= DRAIN;
                    enc_final_flag <= 1'b1;
                    drain_cnt      <= '0;
                end
                DRAIN: begin
                    if (enc_last_in || (drain_cnt == CNT_WIDTH'(DRAIN_TIMEOUT))) begin
                        state         <= IDLE;
                        s_ready       <= 1'b1;
                        busy          <= 1'b0;
                        first_pending <= 1'b1;
                        drain_cnt     <= '0;
                        if (!enc_last_in) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_encoder_sequencer.sv
// Scoreboard bench for entropy_encoder_sequencer: expected issues queued at stimulus time.
module tb_entropy_encoder_sequencer;

    logic        top_clk = 1'b0;
    logic        top_reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_fl;
    logic [15:0] s_fh;
    logic [3:0]  s_symbol;
    logic [4:0]  s_nsyms;
    logic        s_bool;
    logic        s_last;
    logic        enc_valid;
    logic [15:0] enc_fl;
    logic [15:0] enc_fh;
    logic [4:0]  enc_nsyms;
    logic [3:0]  enc_symbol_1;
    logic [3:0]  enc_symbol_2;
    logic [3:0]  enc_symbol_3;
    logic        enc_bool_1;
    logic        enc_bool_2;
    logic        enc_bool_3;
    logic        enc_flag_first;
    logic        enc_final_flag;
    logic        enc_last_in;
    logic        busy;
    logic        err_timeout;

    typedef struct packed {
        logic [15:0] fl;
        logic [15:0] fh;
        logic [4:0]  nsyms;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  s3;
        logic        b1;
        logic        b2;
        logic        b3;
        logic        ff;
    } exp_t;

    exp_t sb[$];
    int   issue_cycles[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_issue_cyc = 0;

    entropy_encoder_sequencer dut (
        .top_clk        (top_clk),
        .top_reset      (top_reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_fl           (s_fl),
        .s_fh           (s_fh),
        .s_symbol       (s_symbol),
        .s_nsyms        (s_nsyms),
        .s_bool         (s_bool),
        .s_last         (s_last),
        .enc_valid      (enc_valid),
        .enc_fl         (enc_fl),
        .enc_fh         (enc_fh),
        .enc_nsyms      (enc_nsyms),
        .enc_symbol_1   (enc_symbol_1),
        .enc_symbol_2   (enc_symbol_2),
        .enc_symbol_3   (enc_symbol_3),
        .enc_bool_1     (enc_bool_1),
        .enc_bool_2     (enc_bool_2),
        .enc_bool_3     (enc_bool_3),
        .enc_flag_first (enc_flag_first),
        .enc_final_flag (enc_final_flag),
        .enc_last_in    (enc_last_in),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    always #5 top_clk = ~top_clk;

    always @(posedge top_clk) cyc <= cyc + 1;

    // Expected record for a bool group of n lanes sharing probability fl.
    function automatic exp_t bool_issue(input logic [15:0] fl, input int n,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic ff);
        exp_t e;
        e.fl = fl; e.fh = 16'h0; e.nsyms = 5'd2;
        e.s1 = a; e.s2 = (n > 1) ? b : 4'h0; e.s3 = (n > 2) ? c : 4'h0;
        e.b1 = 1'b1; e.b2 = (n > 1); e.b3 = (n > 2); e.ff = ff;
        return e;
    endfunction

    function automatic exp_t sym_issue(input logic [15:0] fl, input logic [15:0] fh,
                                       input logic [4:0] ns, input logic [3:0] s, input logic ff);
        exp_t e;
        e = '0;
        e.fl = fl; e.fh = fh; e.nsyms = ns; e.s1 = s; e.ff = ff;
        return e;
    endfunction

    // Scoreboard: every enc_valid cycle must match the next queued expectation.
    always @(negedge top_clk) begin
        exp_t act;
        exp_t want;
        if (enc_valid === 1'b1) begin
            act = {enc_fl, enc_fh, enc_nsyms, enc_symbol_1, enc_symbol_2, enc_symbol_3,
                   enc_bool_1, enc_bool_2, enc_bool_3, enc_flag_first};
            last_issue_cyc = cyc;
            issue_cycles.push_back(cyc);
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue got=%h want=none", act);
            end else begin
                want = sb.pop_front();
                if (act !== want) begin
                    bad++;
                    $display("FAIL issue_payload got=%h want=%h", act, want);
                end
            end
        end
    end

    task automatic send(input logic b, input logic [15:0] fl, input logic [15:0] fh,
                        input logic [3:0] sym, input logic [4:0] ns, input logic last);
        @(negedge top_clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL s_ready_at_send got=%b want=1", s_ready);
        end
        s_valid = 1'b1; s_bool = b; s_fl = fl; s_fh = fh;
        s_symbol = sym; s_nsyms = ns; s_last = last;
        @(posedge top_clk);
    endtask

    // Waits for the frame's final flag, checks its timing, optionally completes the drain.
    task automatic finish_frame(input bit do_drain);
        int k = 0;
        do begin
            @(negedge top_clk);
            s_valid = 1'b0;
            k++;
        end while (enc_final_flag !== 1'b1 && k < 30);
        total++;
        if (enc_final_flag !== 1'b1) begin
            bad++;
            $display("FAIL final_flag_timeout got=0 want=1");
            return;
        end
        total++;
        if (cyc != last_issue_cyc + 1) begin
            bad++;
            $display("FAIL final_flag_delay got=%0d want=%0d", cyc - last_issue_cyc, 1);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_issues got=%0d want=0", sb.size());
        end
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL s_ready_in_final got=%b want=0", s_ready);
        end
        if (!do_drain) return;
        for (int i = 0; i < 3; i++) begin
            @(negedge top_clk);
            total++;
            if ({enc_final_flag, s_ready, busy} !== 3'b001) begin
                bad++;
                $display("FAIL drain_hold got=%b want=001", {enc_final_flag, s_ready, busy});
            end
        end
        enc_last_in = 1'b1;
        @(negedge top_clk);
        enc_last_in = 1'b0;
        total++;
        if ({s_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL drain_release got=%b want=10", {s_ready, busy});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [63:0] outs;
        outs = 64'({enc_valid, enc_fl, enc_fh, enc_nsyms, enc_symbol_1, enc_symbol_2, enc_symbol_3,
                    enc_bool_1, enc_bool_2, enc_bool_3, enc_flag_first, enc_final_flag, busy, err_timeout});
        total++;
        if (outs !== 64'h0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s got=%h ready=%b want=0 ready=1", tag, outs, s_ready);
        end
    endtask

    task automatic test_reset;
        top_reset = 1'b1;
        s_valid = 0; s_bool = 0; s_fl = 0; s_fh = 0; s_symbol = 0; s_nsyms = 0; s_last = 0;
        enc_last_in = 0;
        repeat (3) @(negedge top_clk);
        check_reset_outputs("reset_state");
        top_reset = 1'b0;
    endtask

    task automatic test_single_nonbool;
        sb.push_back(sym_issue(16'h4000, 16'h8000, 5'd16, 4'h3, 1'b1));
        send(1'b0, 16'h4000, 16'h8000, 4'h3, 5'd16, 1'b1);
        @(negedge top_clk);
        s_valid = 1'b0;
        total++;
        if (enc_valid !== 1'b0) begin
            bad++;
            $display("FAIL nonbool_early got=%b want=0", enc_valid);
        end
        @(negedge top_clk);
        total++;
        if ({enc_valid, enc_flag_first} !== 2'b11) begin
            bad++;
            $display("FAIL nonbool_issue got=%b want=11", {enc_valid, enc_flag_first});
        end
        finish_frame(1'b1);
    endtask

    task automatic test_five_bools;
        issue_cycles.delete();
        sb.push_back(bool_issue(16'h2000, 3, 4'h1, 4'h0, 4'h1, 1'b1));
        sb.push_back(bool_issue(16'h2000, 2, 4'h1, 4'h0, 4'h0, 1'b0));
        send(1'b1, 16'h2000, 16'h1234, 4'h1, 5'd2, 1'b0);
        send(1'b1, 16'h2000, 16'h1234, 4'h0, 5'd2, 1'b0);
        send(1'b1, 16'h2000, 16'h1234, 4'h1, 5'd2, 1'b0);
        send(1'b1, 16'h2000, 16'h1234, 4'h1, 5'd2, 1'b0);
        send(1'b1, 16'h2000, 16'h1234, 4'h0, 5'd2, 1'b1);
        finish_frame(1'b1);
        total++;
        if (issue_cycles.size() != 2) begin
            bad++;
            $display("FAIL five_bools_issue_count got=%0d want=2", issue_cycles.size());
        end
    endtask

    task automatic test_back_to_back;
        issue_cycles.delete();
        sb.push_back(bool_issue(16'h2000, 1, 4'h1, 4'h0, 4'h0, 1'b1));
        sb.push_back(bool_issue(16'h3000, 2, 4'h0, 4'h1, 4'h0, 1'b0));
        sb.push_back(sym_issue(16'h1000, 16'h5000, 5'd9, 4'h5, 1'b0));
        send(1'b1, 16'h2000, 16'h0, 4'h1, 5'd2, 1'b0);
        send(1'b1, 16'h3000, 16'h0, 4'h0, 5'd2, 1'b0);
        send(1'b1, 16'h3000, 16'h0, 4'h1, 5'd2, 1'b0);
        send(1'b0, 16'h1000, 16'h5000, 4'h5, 5'd9, 1'b1);
        finish_frame(1'b1);
        total++;
        if (issue_cycles.size() != 3) begin
            bad++;
            $display("FAIL b2b_issue_count got=%0d want=3", issue_cycles.size());
        end else begin
            total++;
            if (issue_cycles[2] != issue_cycles[1] + 1) begin
                bad++;
                $display("FAIL b2b_gap got=%0d want=1", issue_cycles[2] - issue_cycles[1]);
            end
        end
    endtask

    task automatic test_timeout;
        int k = 0;
        sb.push_back(sym_issue(16'h0100, 16'h0200, 5'd5, 4'h2, 1'b1));
        send(1'b0, 16'h0100, 16'h0200, 4'h2, 5'd5, 1'b1);
        finish_frame(1'b0);
        while (busy === 1'b1 && k < 200) begin
            @(negedge top_clk);
            k++;
        end
        total++;
        if ({busy, s_ready, err_timeout} !== 3'b011) begin
            bad++;
            $display("FAIL timeout_exit got=%b want=011", {busy, s_ready, err_timeout});
        end
        total++;
        if (k < 64 || k > 66) begin
            bad++;
            $display("FAIL timeout_length got=%0d want=64..66", k);
        end
    endtask

    task automatic test_withheld;
        sb.push_back(bool_issue(16'h2000, 2, 4'h1, 4'h0, 4'h0, 1'b1));
        send(1'b1, 16'h2000, 16'h0, 4'h1, 5'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge top_clk);
            s_valid = 1'b0;
            total++;
            if (enc_valid !== 1'b0) begin
                bad++;
                $display("FAIL withheld_issue cycle=%0d got=%b want=0", i, enc_valid);
            end
        end
        send(1'b1, 16'h2000, 16'h0, 4'h0, 5'd2, 1'b1);
        finish_frame(1'b1);
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", err_timeout);
        end
    endtask

    task automatic test_reset_mid_group;
        send(1'b1, 16'h2000, 16'h0, 4'h1, 5'd2, 1'b0);
        send(1'b1, 16'h2000, 16'h0, 4'h0, 5'd2, 1'b0);
        @(negedge top_clk);
        s_valid = 1'b0;
        top_reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_group");
        @(negedge top_clk);
        top_reset = 1'b0;
        sb.push_back(bool_issue(16'h2000, 1, 4'h1, 4'h0, 4'h0, 1'b1));
        send(1'b1, 16'h2000, 16'h0, 4'h1, 5'd2, 1'b1);
        finish_frame(1'b1);
    endtask

    initial begin
        test_reset();
        test_single_nonbool();
        test_five_bools();
        test_back_to_back();
        test_timeout();
        test_withheld();
        test_reset_mid_group();
        repeat (3) @(negedge top_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
